// File: rtl/led_disp_pkg.sv
// Shared display constants: logical (active-high) hex-to-segment table in {g,f,e,d,c,b,a} order,
// the all-dark pattern and the digit-select state type used by the scanner.
package led_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // 0-9, A, b, C, d, E, F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    DIGIT_LO = 1'b0,
    DIGIT_HI = 1'b1
  } digit_sel_e;

  function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble decoder producing the logical (active-high) 7-segment pattern.
module hex_to_seg7
  import led_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // table lookup, no polarity handling here
  always_comb begin
    pattern = hex_seg(nibble);
  end

endmodule

// File: rtl/led_hex_scan.sv
// Two-digit multiplexed hex display driver with per-slot dead time, PWM dimming and
// frame-aligned sampling of the displayed byte; all outputs registered.
module led_hex_scan
  import led_disp_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 64,
  parameter int PWM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          value,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [1:0]          dig,
  output logic                frame_tick
);

  localparam int DIV   = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  localparam logic [6:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [1:0] DIG_MASK = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [CNT_W-1:0]    slot_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [7:0]          shadow_r;
  digit_sel_e          sel_r;
  digit_sel_e          sel_next_s;

  logic       slot_wrap_s;
  logic       frame_start_s;
  logic [3:0] nibble_s;
  logic [6:0] pattern_s;
  logic       pwm_on_s;
  logic       lz_dark_s;
  logic       digit_on_s;
  logic [1:0] dig_log_s;
  logic [6:0] seg_log_s;

  logic [6:0] seg_r;
  logic       dp_r;
  logic [1:0] dig_r;
  logic       frame_tick_r;

  assign slot_wrap_s   = (slot_cnt_r == SLOT_LAST);
  assign frame_start_s = slot_wrap_s && (sel_r == DIGIT_HI);

  // Slot timer, PWM ramp and frame-aligned shadow capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_r <= {CNT_W{1'b0}};
      pwm_cnt_r  <= {PWM_BITS{1'b0}};
      shadow_r   <= 8'h00;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      if (slot_wrap_s) begin
        slot_cnt_r <= {CNT_W{1'b0}};
      end else begin
        slot_cnt_r <= slot_cnt_r + CNT_W'(1);
      end
      if (frame_start_s) begin
        shadow_r <= value;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  // Digit-select state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r <= DIGIT_LO;
    end else begin
      sel_r <= sel_next_s;
    end
  end

  // Digit-select next state: alternate on every slot wrap
  always_comb begin
    sel_next_s = sel_r;
    if (slot_wrap_s) begin
      case (sel_r)
        DIGIT_LO: sel_next_s = DIGIT_HI;
        DIGIT_HI: sel_next_s = DIGIT_LO;
        default:  sel_next_s = DIGIT_LO;
      endcase
    end else begin
      sel_next_s = sel_r;
    end
  end

  assign nibble_s = (sel_r == DIGIT_HI) ? shadow_r[7:4] : shadow_r[3:0];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // Full scale bypasses the compare so all-ones really means 100 % duty
  assign pwm_on_s   = (&brightness) || (pwm_cnt_r < brightness);
  assign lz_dark_s  = (LZ_BLANK != 0) && (sel_r == DIGIT_HI) && (shadow_r[7:4] == 4'h0);
  assign digit_on_s = (slot_cnt_r >= BLANK_END) && pwm_on_s && !lz_dark_s;

  // Output decode: one-hot digit and its pattern, or everything dark
  always_comb begin
    dig_log_s = 2'b00;
    seg_log_s = SEG_OFF;
    if (digit_on_s) begin
      case (sel_r)
        DIGIT_LO: dig_log_s = 2'b01;
        DIGIT_HI: dig_log_s = 2'b10;
        default:  dig_log_s = 2'b00;
      endcase
      seg_log_s = pattern_s;
    end else begin
      dig_log_s = 2'b00;
      seg_log_s = SEG_OFF;
    end
  end

  // Output registers with pin polarity applied
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r        <= SEG_OFF ^ SEG_MASK;
      dp_r         <= DP_OFF;
      dig_r        <= DIG_MASK;
      frame_tick_r <= 1'b0;
    end else begin
      seg_r        <= seg_log_s ^ SEG_MASK;
      dp_r         <= DP_OFF;
      dig_r        <= dig_log_s ^ DIG_MASK;
      frame_tick_r <= frame_start_s;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign dig        = dig_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_led_hex_scan.sv
// Randomized self-checking bench: two scanners (leading-zero blanking off/on) compared each
// cycle against a model derived from the cycle count since reset release.
module tb_led_hex_scan;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] value = 8'h00;
  logic [1:0] brightness = 2'd3;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [1:0] dig0, dig1;
  logic       ft0, ft1;

  int tests_run = 0;
  int tests_failed = 0;

  int         n_edges;
  logic [7:0] shadow_m;
  logic [6:0] ref_seg [16];

  always #5 clk = ~clk;

  led_hex_scan #(
    .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .PWM_BITS(2),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .LZ_BLANK(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .value(value), .brightness(brightness),
    .seg(seg0), .dp(dp0), .dig(dig0), .frame_tick(ft0)
  );

  led_hex_scan #(
    .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2), .PWM_BITS(2),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .LZ_BLANK(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .value(value), .brightness(brightness),
    .seg(seg1), .dp(dp1), .dig(dig1), .frame_tick(ft1)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  // Physical {dig, seg} after the next edge, given n edges since release have already occurred
  function automatic logic [8:0] expect_out(input int n, input logic [7:0] sh,
                                            input logic [1:0] br, input bit lz);
    int         slot;
    int         sel;
    int         pwm;
    logic [3:0] nib;
    bit         on;
    logic [1:0] dl;
    logic [6:0] sl;
    slot = n % 10;
    sel  = (n / 10) % 2;
    pwm  = n % 4;
    nib  = (sel == 1) ? sh[7:4] : sh[3:0];
    on   = (slot >= 2) && ((br == 2'd3) || (pwm < int'(br))) &&
           !(lz && (sel == 1) && (sh[7:4] == 4'h0));
    dl = 2'b00;
    sl = 7'h00;
    if (on) begin
      dl = (sel == 1) ? 2'b10 : 2'b01;
      sl = ref_seg[nib];
    end
    return {~dl, ~sl};
  endfunction

  task automatic step();
    logic [8:0] e0;
    logic [8:0] e1;
    logic [7:0] v;
    bit         ft_exp;
    e0 = expect_out(n_edges, shadow_m, brightness, 1'b0);
    e1 = expect_out(n_edges, shadow_m, brightness, 1'b1);
    v  = value;
    @(posedge clk);
    #1;
    n_edges++;
    ft_exp = ((n_edges % 20) == 0);
    if (ft_exp) shadow_m = v;
    check_eq("dig_lz0", {14'd0, dig0}, {14'd0, e0[8:7]});
    check_eq("seg_lz0", {9'd0, seg0}, {9'd0, e0[6:0]});
    check_eq("dig_lz1", {14'd0, dig1}, {14'd0, e1[8:7]});
    check_eq("seg_lz1", {9'd0, seg1}, {9'd0, e1[6:0]});
    check_eq("ft_lz0", {15'd0, ft0}, {15'd0, ft_exp});
    check_eq("ft_lz1", {15'd0, ft1}, {15'd0, ft_exp});
    check_eq("dp", {14'd0, dp0, dp1}, 16'h0003);
    check_eq("dig_excl", {14'd0, (dig0 == 2'b00), (dig1 == 2'b00)}, 16'h0000);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_dig"}, {12'd0, dig0, dig1}, 16'h000F);
    check_eq({tag, "_seg0"}, {9'd0, seg0}, 16'h007F);
    check_eq({tag, "_seg1"}, {9'd0, seg1}, 16'h007F);
    check_eq({tag, "_ft"}, {14'd0, ft0, ft1}, 16'h0000);
    check_eq({tag, "_dp"}, {14'd0, dp0, dp1}, 16'h0003);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    n_edges  = 0;
    shadow_m = 8'h00;
  endtask

  initial begin
    ref_seg[0]  = 7'h3F; ref_seg[1]  = 7'h06; ref_seg[2]  = 7'h5B; ref_seg[3]  = 7'h4F;
    ref_seg[4]  = 7'h66; ref_seg[5]  = 7'h6D; ref_seg[6]  = 7'h7D; ref_seg[7]  = 7'h07;
    ref_seg[8]  = 7'h7F; ref_seg[9]  = 7'h6F; ref_seg[10] = 7'h77; ref_seg[11] = 7'h7C;
    ref_seg[12] = 7'h39; ref_seg[13] = 7'h5E; ref_seg[14] = 7'h79; ref_seg[15] = 7'h71;
    n_edges  = 0;
    shadow_m = 8'h00;

    // Held in reset across a few edges
    value      = 8'hA5;
    brightness = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst_init");

    // First frame, then A5 shown
    release_reset();
    run(60);

    // Mid-frame change (high digit slot) must wait for the next frame start
    while ((n_edges % 20) != 13) step();
    value = 8'h3C;
    run(40);

    // Dimming: 25 % duty, then fully dark
    brightness = 2'd1;
    run(40);
    brightness = 2'd0;
    run(40);
    brightness = 2'd3;

    // Leading-zero blanking cases
    value = 8'h07;
    run(60);
    value = 8'h10;
    run(60);

    // Asynchronous reset mid-slot while a digit is lit
    while ((n_edges % 10) != 5) step();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    value = 8'h5A;
    release_reset();
    run(45);

    // Every nibble through both digits
    for (int v = 0; v < 16; v++) begin
      value = {v[3:0], 4'(15 - v)};
      run(40);
    end

    // Random value every cycle, occasional brightness changes
    for (int i = 0; i < 1500; i++) begin
      value = 8'($urandom);
      if ((i % 97) == 0) brightness = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
